// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: immediate extraction and sign/zero extension behind a small
// valid/ready buffer. Illegal formats pass through with out_imm=0, out_err=1.
// Build option: define IMM_EXT_SKID_EN for a 2-entry skid buffer that sustains
// one item per cycle; otherwise a single entry is used (one item per 2 cycles).
//
// state | meaning
// EMPTY | no item held, out_valid=0
// ONE   | head entry holds an item
// TWO   | head and tail both hold items, in_ready=0 (skid build only)
module imm_ext_pipe #(
    parameter int XLEN = 32,
    parameter int N    = 12
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [2:0]      in_fmt,
    input  logic            in_unsigned,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic            out_err
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic              accept, drain;
    logic              load_head_in, load_head_tail, load_tail;
    logic              sgn;
    logic [XLEN-1:0]   new_imm;
    logic              new_err;
    logic [XLEN-1:0]   head_imm;
    logic              head_err;
`ifdef IMM_EXT_SKID_EN
    logic [XLEN-1:0]   tail_imm;
    logic              tail_err;
`endif

    assign accept    = in_valid && in_ready;
    assign out_valid = (state != EMPTY);
    assign drain     = out_valid && out_ready;
    assign out_imm   = head_imm;
    assign out_err   = head_err;

    // Assemble the raw immediate for the selected format and extend it to XLEN.
    always_comb begin
        sgn     = 1'b0;
        new_imm = '0;
        new_err = 1'b0;
        case (in_fmt)
            3'd0: begin
                sgn     = ~in_unsigned & in_instr[31];
                new_imm = {{(XLEN-12){sgn}}, in_instr[31:20]};
            end
            3'd1: begin
                sgn     = ~in_unsigned & in_instr[31];
                new_imm = {{(XLEN-12){sgn}}, in_instr[31:25], in_instr[11:7]};
            end
            3'd2: begin
                sgn     = ~in_unsigned & in_instr[31];
                new_imm = {{(XLEN-13){sgn}}, in_instr[31], in_instr[7],
                           in_instr[30:25], in_instr[11:8], 1'b0};
            end
            3'd3: begin
                sgn     = ~in_unsigned & in_instr[31];
                new_imm = {{(XLEN-32){sgn}}, in_instr[31:12], 12'b0};
            end
            3'd4: begin
                sgn     = ~in_unsigned & in_instr[31];
                new_imm = {{(XLEN-21){sgn}}, in_instr[31], in_instr[19:12],
                           in_instr[20], in_instr[30:21], 1'b0};
            end
            3'd5: begin
                // Loop form handles N == XLEN, where a replication would be empty.
                sgn = ~in_unsigned & in_instr[N-1];
                new_imm[N-1:0] = in_instr[N-1:0];
                for (int i = N; i < XLEN; i++) begin
                    new_imm[i] = sgn;
                end
            end
            default: new_err = 1'b1;
        endcase
    end

    // Next buffer state and which entry loads from where.
    always_comb begin
        state_nxt      = state;
        load_head_in   = 1'b0;
        load_head_tail = 1'b0;
        load_tail      = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt    = ONE;
                    load_head_in = 1'b1;
                end
            end
            ONE: begin
`ifdef IMM_EXT_SKID_EN
                if (accept && drain) begin
                    load_head_in = 1'b1;
                end else if (accept) begin
                    state_nxt = TWO;
                    load_tail = 1'b1;
                end else if (drain) begin
                    state_nxt = EMPTY;
                end
`else
                if (drain) begin
                    state_nxt = EMPTY;
                end
`endif
            end
`ifdef IMM_EXT_SKID_EN
            TWO: begin
                if (drain) begin
                    state_nxt      = ONE;
                    load_head_tail = 1'b1;
                end
            end
`endif
            default: state_nxt = EMPTY;
        endcase
    end

    // State register and registered in_ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= state_nxt;
`ifdef IMM_EXT_SKID_EN
            in_ready <= (state_nxt != TWO);
`else
            in_ready <= (state_nxt == EMPTY);
`endif
        end
    end

    // Head entry: loads from the input or advances from the tail.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_imm <= '0;
            head_err <= 1'b0;
        end else if (load_head_in) begin
            head_imm <= new_imm;
            head_err <= new_err;
`ifdef IMM_EXT_SKID_EN
        end else if (load_head_tail) begin
            head_imm <= tail_imm;
            head_err <= tail_err;
`endif
        end
    end

`ifdef IMM_EXT_SKID_EN
    // Tail entry: catches an item arriving while the head is stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            tail_imm <= '0;
            tail_err <= 1'b0;
        end else if (load_tail) begin
            tail_imm <= new_imm;
            tail_err <= new_err;
        end
    end
`endif

endmodule
